// File: rtl/logic_pipe.sv
// logic_pipe: bitwise AND/OR/XOR/NOR unit with an accumulator and a 2-entry result FIFO
module logic_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clear,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             zero
);
  logic [1:0]       cnt;
  logic [WIDTH-1:0] acc, a, res, second_data;
  logic             second_zero, push, pop, to_head;
  assign in_ready  = reset_n && (cnt < 2'd2);
  assign out_valid = cnt != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign a         = acc_sel ? acc : data_operandA;
  // new result goes straight to head when the FIFO is empty or its only entry is leaving
  assign to_head   = cnt == 2'd0 || (cnt == 2'd1 && pop);
  always_comb
    res = op == 2'b00 ? a & data_operandB :
          op == 2'b01 ? a | data_operandB :
          op == 2'b10 ? a ^ data_operandB : ~(a | data_operandB);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      data_result <= '0;
      zero        <= 1'b0;
      second_data <= '0;
      second_zero <= 1'b0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      acc <= acc_clear ? '0 : push ? res : acc;
      if (push && to_head) begin
        data_result <= res;
        zero        <= res == '0;
      end else if (pop && cnt == 2'd2) begin
        data_result <= second_data;
        zero        <= second_zero;
      end
      if (push && !to_head) begin
        second_data <= res;
        second_zero <= res == '0;
      end
    end
endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: directed checks of logic_pipe at WIDTH=32
module tb_logic_pipe;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, acc_sel = 1'b0, acc_clear = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic        out_valid, out_ready = 1'b0, zero;
  int total = 0, bad = 0;
  logic [31:0] ops_exp [4] = '{32'h0F0F_0000, 32'hFFFF_0F0F, 32'hF0F0_0F0F, 32'h0000_F0F0};
  logic_pipe #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_sel(acc_sel), .acc_clear(acc_clear),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_result(data_result), .zero(zero)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic req(input logic [1:0] o, input logic sel, input logic [31:0] av, input logic [31:0] bv);
    in_valid = 1'b1; op = o; acc_sel = sel; data_operandA = av; data_operandB = bv;
  endtask
  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", data_result, 0);
    chk("rst_zero", zero, 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    req(2'b01, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    step();
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_res0", data_result, 32'h0000_00FF);
    chk("b2b_zero0", zero, 0);
    req(2'b00, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    step();
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_res1", data_result, 0);
    chk("b2b_zero1", zero, 1);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      req(i[1:0], 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
      step();
      chk($sformatf("op%0d_res", i), data_result, ops_exp[i]);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    req(2'b01, 1'b0, 32'd1, 32'd0);
    step();
    chk("bp_ready1", in_ready, 1);
    req(2'b01, 1'b0, 32'd2, 32'd0);
    step();
    chk("bp_ready2", in_ready, 0);
    chk("bp_head2", data_result, 1);
    req(2'b01, 1'b0, 32'd3, 32'd0);
    step();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_head", data_result, 1);
    out_ready = 1'b1;
    step();
    chk("bp_pop1", data_result, 2);
    step();
    chk("bp_pop2", data_result, 3);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    req(2'b10, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    step();
    chk("acc_x1", data_result, 32'h1234_5678);
    chk("acc_x1_zero", zero, 0);
    step();
    chk("acc_x2", data_result, 0);
    chk("acc_x2_zero", zero, 1);
    req(2'b01, 1'b0, 32'hAAAA_AAAA, 32'h0);
    step();
    req(2'b01, 1'b1, 32'h0, 32'h5555_5555);
    acc_clear = 1'b1;
    step();
    chk("clr_res", data_result, 32'hFFFF_FFFF);
    acc_clear = 1'b0;
    req(2'b01, 1'b1, 32'h1111_1111, 32'h0);
    step();
    chk("clr_after", data_result, 0);
    chk("clr_after_zero", zero, 1);
    out_ready = 1'b0;
    req(2'b01, 1'b0, 32'h0000_0005, 32'h0);
    step();
    req(2'b01, 1'b0, 32'h0000_0006, 32'h0);
    step();
    in_valid = 1'b0;
    chk("q2_valid", out_valid, 1);
    chk("q2_ready", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_result", data_result, 0);
    chk("ar_ready", in_ready, 0);
    step();
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ar_rel_ready", in_ready, 1);
    chk("ar_rel_valid", out_valid, 0);
    step();
    chk("ar_no_stale", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
